// File: rtl/pucch_alpha_seq_generator.sv
// rtl/pucch_alpha_seq_generator.sv - PUCCH per-symbol cyclic-shift (alpha) generator with Gold-sequence engine
module pucch_alpha_seq_generator #(
    parameter int NUM_SC  = 12,
    parameter int ALPHA_W = 4,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_ext_cp,
    input  logic [3:0]         i_m0,
    input  logic [3:0]         i_mcs,
    input  logic [5:0]         i_mint,
    input  logic [7:0]         i_nslot,
    input  logic [9:0]         i_nid,
    input  logic [3:0]         i_start_symb,
    input  logic [3:0]         i_num_symb,
    input  logic               i_ready,
    output logic               o_busy,
    output logic [ALPHA_W-1:0] o_alpha,
    output logic [3:0]         o_symb,
    output logic               o_valid,
    output logic               o_last,
    output logic               o_done,
    output logic               o_err
);
    localparam logic [4:0]  NSC5     = 5'(NUM_SC);
    localparam logic [8:0]  NSC9     = 9'(NUM_SC);
    localparam logic [15:0] STEP16   = 16'(STEP);
    localparam logic [3:0]  GEN_LAST = 4'(8 / STEP - 1);

    typedef enum logic [2:0] {IDLE, SKIP, GEN, MOD, OUT} state_t;

    state_t             state_q, state_d;
    logic [30:0]        x1_q, x1_d, x2_q, x2_d, x1_adv, x2_adv;
    logic [STEP-1:0]    c_bits;
    logic [15:0]        skip_q, skip_d, skip_init;
    logic [3:0]         gen_cnt_q, gen_cnt_d;
    logic [7:0]         ncs_q, ncs_d;
    logic [3:0]         m0_q, m0_d, mcs_q, mcs_d, last_symb_q, last_symb_d;
    logic [5:0]         mint_q, mint_d;
    logic [ALPHA_W-1:0] alpha_d;
    logic [3:0]         symb_d;
    logic               valid_d, last_d, busy_d, done_d, err_d;
    logic [4:0]         nsymb;
    logic [7:0]         nslot_max;
    logic               cfg_bad;
    logic [11:0]        sym_idx;
    logic [8:0]         sum;

    always_comb begin
        nsymb     = i_ext_cp ? 5'd12 : 5'd14;
        nslot_max = i_ext_cp ? 8'd39 : 8'd159;
        cfg_bad   = (i_num_symb == 4'd0)
                 || (({1'b0, i_start_symb} + {1'b0, i_num_symb}) > nsymb)
                 || ({1'b0, i_m0} >= NSC5) || ({1'b0, i_mcs} >= NSC5)
                 || (i_nslot > nslot_max);
        // bits to discard: 1600 warm-up plus 8 per preceding symbol in the frame
        sym_idx   = {7'd0, nsymb} * {4'd0, i_nslot} + {8'd0, i_start_symb};
        skip_init = 16'd1600 + {1'b0, sym_idx, 3'b000};
    end

    // unrolled Gold-sequence advance; c_bits[0] is the oldest bit of this step
    always_comb begin
        x1_adv = x1_q;
        x2_adv = x2_q;
        c_bits = '0;
        for (int j = 0; j < STEP; j++) begin
            c_bits[j] = x1_adv[0] ^ x2_adv[0];
            x1_adv    = {x1_adv[3] ^ x1_adv[0], x1_adv[30:1]};
            x2_adv    = {x2_adv[3] ^ x2_adv[2] ^ x2_adv[1] ^ x2_adv[0], x2_adv[30:1]};
        end
    end

    assign sum = {5'd0, m0_q} + {5'd0, mcs_q} + {3'd0, mint_q} + {1'b0, ncs_q};

    always_comb begin
        state_d     = state_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        skip_d      = skip_q;
        gen_cnt_d   = gen_cnt_q;
        ncs_d       = ncs_q;
        m0_d        = m0_q;
        mcs_d       = mcs_q;
        mint_d      = mint_q;
        last_symb_d = last_symb_q;
        alpha_d     = o_alpha;
        symb_d      = o_symb;
        valid_d     = o_valid;
        last_d      = o_last;
        busy_d      = o_busy;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (i_start) begin
            // a start in any state abandons the running occasion without o_done
            alpha_d = '0;
            symb_d  = 4'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (cfg_bad) begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                x1_d        = 31'd1;
                x2_d        = {21'd0, i_nid};
                skip_d      = skip_init;
                m0_d        = i_m0;
                mcs_d       = i_mcs;
                mint_d      = i_mint;
                symb_d      = i_start_symb;
                last_symb_d = i_start_symb + i_num_symb - 4'd1;
                busy_d      = 1'b1;
                state_d     = SKIP;
            end
        end else begin
            case (state_q)
                SKIP: begin
                    x1_d   = x1_adv;
                    x2_d   = x2_adv;
                    skip_d = skip_q - STEP16;
                    if (skip_q == STEP16) begin
                        gen_cnt_d = 4'd0;
                        state_d   = GEN;
                    end
                end
                GEN: begin
                    x1_d      = x1_adv;
                    x2_d      = x2_adv;
                    ncs_d     = (ncs_q >> STEP) | (8'(c_bits) << (8 - STEP));
                    gen_cnt_d = gen_cnt_q + 4'd1;
                    if (gen_cnt_q == GEN_LAST) state_d = MOD;
                end
                MOD: begin
                    alpha_d = ALPHA_W'(sum % NSC9);
                    valid_d = 1'b1;
                    last_d  = (o_symb == last_symb_q);
                    state_d = OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        if (o_last) begin
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            symb_d    = o_symb + 4'd1;
                            gen_cnt_d = 4'd0;
                            state_d   = GEN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x1_q        <= '0;
            x2_q        <= '0;
            skip_q      <= '0;
            gen_cnt_q   <= '0;
            ncs_q       <= '0;
            m0_q        <= '0;
            mcs_q       <= '0;
            mint_q      <= '0;
            last_symb_q <= '0;
            o_alpha     <= '0;
            o_symb      <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            skip_q      <= skip_d;
            gen_cnt_q   <= gen_cnt_d;
            ncs_q       <= ncs_d;
            m0_q        <= m0_d;
            mcs_q       <= mcs_d;
            mint_q      <= mint_d;
            last_symb_q <= last_symb_d;
            o_alpha     <= alpha_d;
            o_symb      <= symb_d;
            o_valid     <= valid_d;
            o_last      <= last_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_err       <= err_d;
        end
    end
endmodule

// File: tb/tb_pucch_alpha_seq_generator.sv
// tb/tb_pucch_alpha_seq_generator.sv - bench for pucch_alpha_seq_generator (STEP=1 and STEP=8 instances)
module tb_pucch_alpha_seq_generator;
    localparam int NBITS = 1600 + 8 * 14 * 160 + 40;

    logic       clk = 1'b0;
    logic       rst, start1, start8, i_ext_cp, i_ready, sel;
    logic [3:0] i_m0, i_mcs, i_start_symb, i_num_symb;
    logic [5:0] i_mint;
    logic [7:0] i_nslot;
    logic [9:0] i_nid;
    logic [3:0] a1, a8, s1, s8, o_alpha, o_symb;
    logic       v1, v8, l1, l8, b1, b8, d1, d8, e1, e8;
    logic       o_valid, o_last, o_busy, o_done, o_err;
    int         tests = 0, fails = 0, done_cnt1 = 0;
    bit         x1a [NBITS];
    bit         x2a [NBITS];

    always #5 clk = ~clk;

    pucch_alpha_seq_generator #(.NUM_SC(12), .ALPHA_W(4), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_ext_cp(i_ext_cp), .i_m0(i_m0), .i_mcs(i_mcs),
        .i_mint(i_mint), .i_nslot(i_nslot), .i_nid(i_nid), .i_start_symb(i_start_symb),
        .i_num_symb(i_num_symb), .i_ready(i_ready), .o_busy(b1), .o_alpha(a1), .o_symb(s1),
        .o_valid(v1), .o_last(l1), .o_done(d1), .o_err(e1));

    pucch_alpha_seq_generator #(.NUM_SC(12), .ALPHA_W(4), .STEP(8)) u_dut8 (
        .clk(clk), .rst(rst), .i_start(start8), .i_ext_cp(i_ext_cp), .i_m0(i_m0), .i_mcs(i_mcs),
        .i_mint(i_mint), .i_nslot(i_nslot), .i_nid(i_nid), .i_start_symb(i_start_symb),
        .i_num_symb(i_num_symb), .i_ready(i_ready), .o_busy(b8), .o_alpha(a8), .o_symb(s8),
        .o_valid(v8), .o_last(l8), .o_done(d8), .o_err(e8));

    always_comb begin
        o_alpha = sel ? a8 : a1;
        o_symb  = sel ? s8 : s1;
        o_valid = sel ? v8 : v1;
        o_last  = sel ? l8 : l1;
        o_busy  = sel ? b8 : b1;
        o_done  = sel ? d8 : d1;
        o_err   = sel ? e8 : e1;
    end

    always @(posedge clk) if (d1) done_cnt1 <= done_cnt1 + 1;

    // Gold sequence straight from its recurrences, kept as whole bit arrays
    function automatic void build_c(input int nid);
        for (int n = 0; n < 31; n++) begin
            x1a[n] = (n == 0);
            x2a[n] = (n < 10) ? nid[n] : 1'b0;
        end
        for (int n = 0; n < NBITS - 31; n++) begin
            x1a[n + 31] = x1a[n + 3] ^ x1a[n];
            x2a[n + 31] = x2a[n + 3] ^ x2a[n + 2] ^ x2a[n + 1] ^ x2a[n];
        end
    endfunction

    function automatic int ref_alpha(input int ext, nslot, l, m0, mcs, mint);
        int nsymb = (ext != 0) ? 12 : 14;
        int base  = 8 * nsymb * nslot + 8 * l + 1600;
        int ncs   = 0;
        for (int m = 0; m < 8; m++) ncs += int'(x1a[base + m] ^ x2a[base + m]) << m;
        return (m0 + mcs + mint + ncs) % 12;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_occ(input bit s, input bit ext, input int nid, nslot, l0, num, m0, mcs, mint,
                             input bit ok, input string tag);
        @(negedge clk);
        sel = s; i_ext_cp = ext; i_nid = 10'(nid); i_nslot = 8'(nslot);
        i_start_symb = 4'(l0); i_num_symb = 4'(num); i_m0 = 4'(m0); i_mcs = 4'(mcs); i_mint = 6'(mint);
        if (s) start8 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start8 = 1'b0;
        i_ext_cp = 1'($urandom); i_nid = 10'($urandom); i_nslot = 8'($urandom); i_start_symb = 4'($urandom);
        i_num_symb = 4'($urandom); i_m0 = 4'($urandom); i_mcs = 4'($urandom); i_mint = 6'($urandom);
        check({tag, "/busy"}, o_busy, ok);
        check({tag, "/err"}, o_err, !ok);
        check({tag, "/valid0"}, o_valid, 0);
        if (!ok) begin
            @(negedge clk);
            check({tag, "/err_pulse"}, o_err, 0);
            check({tag, "/busy_idle"}, o_busy, 0);
        end
    endtask

    task automatic run_occ(input bit s, input bit ext, input int nid, nslot, l0, num, m0, mcs, mint,
                           input bit rnd, input string tag);
        int step, lat, cyc, exp_a, stall;
        step = s ? 8 : 1;
        lat  = 1 + (1600 + 8 * ((ext ? 12 : 14) * nslot + l0)) / step + 8 / step;
        build_c(nid);
        start_occ(s, ext, nid, nslot, l0, num, m0, mcs, mint, 1'b1, tag);
        for (int k = 0; k < num; k++) begin
            exp_a = ref_alpha(ext, nslot, l0 + k, m0, mcs, mint);
            cyc = 0;
            while (!o_valid && cyc < lat + 20) begin
                if (rnd) i_ready = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
            check($sformatf("%s/lat%0d", tag, k), cyc, lat);
            check($sformatf("%s/alpha%0d", tag, k), o_alpha, exp_a);
            check($sformatf("%s/symb%0d", tag, k), o_symb, l0 + k);
            check($sformatf("%s/last%0d", tag, k), o_last, k == num - 1);
            stall = rnd ? $urandom_range(0, 20) : 0;
            if (stall > 0) begin
                i_ready = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    check($sformatf("%s/hold_alpha%0d", tag, k), o_alpha, exp_a);
                    check($sformatf("%s/hold_symb%0d", tag, k), o_symb, l0 + k);
                    check($sformatf("%s/hold_valid%0d", tag, k), o_valid, 1);
                end
            end
            i_ready = 1'b1;
            @(negedge clk);
            if (rnd) i_ready = 1'b0;
            check($sformatf("%s/valid_low%0d", tag, k), o_valid, 0);
            if (k == num - 1) begin
                check({tag, "/busy_end"}, o_busy, 0);
                check({tag, "/last_end"}, o_last, 0);
                check({tag, "/done"}, o_done, 1);
                @(negedge clk);
                check({tag, "/done_pulse"}, o_done, 0);
            end else begin
                check($sformatf("%s/no_done%0d", tag, k), o_done, 0);
            end
            lat = 8 / step + 1;
        end
    endtask

    initial begin : main
        int r_ext, r_ns, r_nslot, r_l0, r_num, cyc, dc0;
        rst = 1'b1; start1 = 1'b0; start8 = 1'b0; sel = 1'b0; i_ready = 1'b0; i_ext_cp = 1'b0;
        i_m0 = '0; i_mcs = '0; i_mint = '0; i_nslot = '0; i_nid = '0; i_start_symb = '0; i_num_symb = '0;
        repeat (3) @(negedge clk);
        check("reset/dut1", {a1, s1, v1, l1, b1, d1, e1}, 0);
        check("reset/dut8", {a8, s8, v8, l8, b8, d8, e8}, 0);
        rst = 1'b0;

        i_ready = 1'b1;
        run_occ(0, 0, 0, 0, 0, 14, 0, 0, 0, 0, "golden");
        run_occ(0, 0, 1007, 159, 10, 4, 11, 11, 45, 0, "sweep_s1");
        run_occ(1, 0, 1007, 159, 10, 4, 11, 11, 45, 0, "sweep_s8");
        run_occ(0, 1, 555, 39, 0, 12, 3, 7, 20, 1, "ext_cp");
        run_occ(1, 0, 1023, 159, 13, 1, 0, 11, 0, 1, "edge_last");

        start_occ(0, 1, 1, 40, 0, 12, 0, 0, 0, 1'b0, "bad_nslot_ext");
        start_occ(0, 0, 1, 160, 0, 1, 0, 0, 0, 1'b0, "bad_nslot_norm");
        start_occ(1, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0, "bad_num0");
        start_occ(1, 0, 1, 0, 10, 5, 0, 0, 0, 1'b0, "bad_span_norm");
        start_occ(1, 1, 1, 0, 0, 13, 0, 0, 0, 1'b0, "bad_span_ext");
        start_occ(0, 0, 1, 0, 0, 1, 12, 0, 0, 1'b0, "bad_m0");
        start_occ(1, 0, 1, 0, 0, 1, 0, 15, 0, 1'b0, "bad_mcs");

        for (int r = 0; r < 5; r++) begin
            r_ext   = $urandom_range(0, 1);
            r_ns    = r_ext ? 12 : 14;
            r_nslot = (r < 3) ? $urandom_range(0, r_ext ? 39 : 159) : $urandom_range(0, 15);
            r_l0    = $urandom_range(0, r_ns - 1);
            r_num   = $urandom_range(1, r_ns - r_l0);
            run_occ(r < 3, r_ext, $urandom_range(0, 1023), r_nslot, r_l0, r_num, $urandom_range(0, 11),
                    $urandom_range(0, 11), $urandom_range(0, 45), 1, $sformatf("rand%0d", r));
        end

        dc0 = done_cnt1;
        i_ready = 1'b0;
        start_occ(0, 0, 5, 0, 0, 14, 1, 2, 3, 1'b1, "abort_a");
        repeat (100) @(negedge clk);
        check("abort_a/busy_skip", o_busy, 1);
        check("abort_a/valid_skip", o_valid, 0);
        build_c(300);
        start_occ(0, 0, 300, 0, 2, 6, 4, 5, 10, 1'b1, "abort_b");
        cyc = 0;
        while (!o_valid && cyc < 1700) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_b/lat", cyc, 1625);
        check("abort_b/alpha", o_alpha, ref_alpha(0, 0, 2, 4, 5, 10));
        check("abort_b/symb", o_symb, 2);
        repeat (5) @(negedge clk);
        check("abort_b/held", o_valid, 1);
        run_occ(0, 0, 777, 0, 3, 5, 9, 6, 30, 0, "abort_c");
        check("abort/done_count", done_cnt1, dc0 + 1);

        i_ready = 1'b0;
        start_occ(0, 0, 9, 1, 0, 3, 0, 0, 0, 1'b1, "rst_pre");
        repeat (50) @(negedge clk);
        rst = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid/dut1", {a1, s1, v1, l1, b1, d1, e1}, 0);
        rst = 1'b0;
        i_ready = 1'b1;
        run_occ(0, 0, 9, 1, 0, 3, 2, 3, 5, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pucch_alpha_seq_generator.md
# pucch_alpha_seq_generator

Multi-symbol PUCCH cyclic-shift (alpha index) generator per TS 38.211 §6.3.2.2.2, with an internal Gold-sequence (c-sequence) engine. For one configured PUCCH occasion it streams one alpha index per OFDM symbol over a valid/ready handshake. It supports normal/extended CP, arbitrary start symbol and length, interlace offset m_int, and a parametrised c-sequence advance rate. It feeds the PUCCH format 0/1 sequence generators and DMRS generators.

## Interface
- NUM_SC, 12: subcarriers per RB; alpha modulus.
- ALPHA_W, 4: alpha output width; must satisfy 2^ALPHA_W >= NUM_SC.
- STEP, 1: c-sequence bits advanced per clock; legal values 1, 2, 4, 8.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; latches all i_* config and starts (or restarts) an occasion.
- i_ext_cp  in  1  1: extended CP (Nsymb=12), 0: normal (Nsymb=14).
- i_m0  in  4  initial cyclic shift, 0..NUM_SC-1.
- i_mcs  in  4  sequence cyclic shift, 0..NUM_SC-1.
- i_mint  in  6  interlace offset (5*nIRB), 0..45; 0 when interlacing is unused.
- i_nslot  in  8  slot in frame; 0..159 normal CP, 0..39 extended CP.
- i_nid  in  10  hopping ID / NCellID, 0..1023; c_init = i_nid.
- i_start_symb  in  4  first symbol l' in slot.
- i_num_symb  in  4  symbols in occasion, 1..Nsymb.
- i_ready  in  1  consumer accepts o_alpha.
- o_busy  out  1  high from the cycle after a valid i_start until o_done.
- o_alpha  out  ALPHA_W  (m0+mcs+mint+ncs(nslot,l)) mod NUM_SC.
- o_symb  out  4  absolute symbol index l of current o_alpha.
- o_valid  out  1  o_alpha/o_symb/o_last valid.
- o_last  out  1  current o_alpha is the final symbol of the occasion.
- o_done  out  1  one-cycle pulse after the last handshake.
- o_err  out  1  one-cycle pulse on rejected config.

## Operation
- c-sequence: x1 init = 1 (bit0=1, others 0). x2 init = {21'b0, i_nid}. c(n) = x1(n+1600) XOR x2(n+1600). Recurrences:
  - x1(n+31) = x1(n+3) ^ x1(n).
  - x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n).
- STEP bits are produced per clock by an unrolled update.
- ncs(nslot,l) = Σ_{m=0..7} 2^m·c(8·Nsymb·nslot + 8·l + m); the first generated bit is LSB.
- Skip count S = 1600 + 8·(Nsymb·i_nslot + i_start_symb). S is at most 19512 and uses a 16-bit down-counter. S and 8 are always multiples of STEP.
- FSM states: IDLE, SKIP, GEN, MOD, OUT.
  - IDLE + i_start: validate config.
    - Invalid config (num_symb=0, start_symb+num_symb>Nsymb, m0 or mcs >= NUM_SC, nslot out of range): pulse o_err and stay in IDLE.
    - Valid config: load LFSRs, set counter=S and symbol counter, go to SKIP.
  - SKIP: advance STEP bits per cycle, discard them, decrement counter by STEP; when it reaches 0, go to GEN.
  - GEN: advance STEP bits per cycle into the ncs shift register (LSB first) for 8/STEP cycles, then go to MOD.
  - MOD: sum = m0+mcs+mint+ncs (9-bit, max 322). Register sum mod NUM_SC into o_alpha, set o_valid, go to OUT.
  - OUT: hold o_alpha, o_symb, o_last and o_valid until i_ready.
    - On handshake with o_last=0: o_symb++, go to GEN. The LFSR continues without a gap, since consecutive symbols use consecutive 8-bit groups.
    - On handshake with o_last=1: pulse o_done, clear o_busy, go to IDLE.
- i_start in any non-IDLE state aborts the occasion. Outputs clear on the same edge and the new config is processed as from IDLE. No o_done is issued for the aborted occasion.
- i_ready while o_valid=0 is ignored.
- Config inputs are don't-care except in the i_start cycle.

## Timing
- Reset values: all outputs 0; FSM in IDLE; LFSRs 0.
- Call the edge sampling i_start edge T.
  - o_busy rises after T; o_err (if invalid) is high for the single cycle after T.
  - First o_valid rises after edge T + 1 + S/STEP + 8/STEP. Example: STEP=1, nslot=0, l'=0 gives T+1609.
- For a handshake at edge H with o_last=0, the next o_valid rises after edge H + 8/STEP + 1. o_valid is low in between.
- For a handshake at edge H with o_last=1: o_valid, o_busy and o_last are low after H, and o_done is high for the cycle after H.
- o_alpha, o_symb and o_last are stable while o_valid=1 and i_ready=0.
- rst has priority over i_start.

## Test plan
- Reset: assert rst for 3 cycles mid-occasion -> all outputs 0, FSM IDLE; the next i_start behaves normally.
- Golden comparison: nid=0, nslot=0, normal CP, l'=0, num_symb=14, m0=0, mcs=0, mint=0, STEP=1, i_ready=1. Expect 14 alphas equal to the golden model (MATLAB nrPUCCHHoppingInfo) and o_symb=0..13. First o_valid after T+1609. o_last on symb 13. o_done one cycle later.
- Sweep: nid=1007, nslot=159, l'=10, num_symb=4, m0=11, mcs=11, mint=45; repeat for STEP=1,2,4,8. Values must be identical across STEP and match the golden model. First-valid latency = 1+(1600+8·2236)/STEP+8/STEP.
- Extended CP: i_ext_cp=1, nslot=39, l'=0, num_symb=12. Expect Nsymb=12 skip arithmetic and values matching the golden model; nslot=40 -> o_err pulse, o_busy stays 0.
- Backpressure: random i_ready with 0–20 cycle stalls. Outputs hold while stalled, no symbol is lost or duplicated, and gaps between symbols are 8/STEP+1 cycles after each handshake.
- Abort: i_start again while in SKIP and again in OUT with a different nid. The first occasion produces no o_done, and the second occasion's stream matches its golden values exactly.
